// File: rtl/ps2_pkg.sv
// Shared scan-code set 2 constants, decoder state encoding and the key event record
// used by the PS/2 scan-code decoder and its output register.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_OVR0   = 8'h00;
    localparam logic [7:0] SC_OVR1   = 8'hFF;

    // The Pause sequence is E1 followed by seven more bytes.
    localparam logic [2:0] PAUSE_LAST = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
    endfunction

    function automatic logic is_status(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == SC_ECHO) || (b == SC_OVR0) || (b == SC_OVR1);
    endfunction

endpackage

// File: rtl/ps2_evt_reg.sv
// Single-entry valid/ready holding register for decoded key events; refuses new
// events while an unaccepted one is held and reports the drop as an ovf pulse.
module ps2_evt_reg
    import ps2_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  key_evt_t load_evt,
    input  logic     ready,
    output logic     valid,
    output key_evt_t evt,
    output logic     ovf
);

    logic slot_free;

    // A transfer on this edge frees the slot, so a simultaneous load is accepted.
    assign slot_free = !valid || ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            evt   <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (load) begin
                if (slot_free) begin
                    evt   <= load_evt;
                    valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 scan-code set 2 byte sequences (E0/F0 prefixes, E1 Pause) into single
// key events, reports device status bytes, and flags errored or stalled sequences.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 50000,
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_rx_done,
    input  logic [7:0] ps2_rd_data,
    input  logic       ps2_rd_data_err,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       stat_valid,
    output logic [7:0] stat_code,
    output logic       seq_err,
    output logic       ovf
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    dec_state_t      state, state_nxt;
    logic [2:0]      pause_cnt, pause_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic            evt_load, stat_load, err_nxt;
    key_evt_t        evt_data, evt_q;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pause_nxt = pause_cnt;
        to_nxt    = to_cnt;
        evt_load  = 1'b0;
        evt_data  = '{code: ps2_rd_data, ext: 1'b0, brk: 1'b0};
        stat_load = 1'b0;
        err_nxt   = 1'b0;

        if (ps2_rx_done) begin
            to_nxt = '0;
            if (ps2_rd_data_err) begin
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ps2_rd_data == SC_EXT) begin
                            state_nxt = ST_EXT;
                        end else if (ps2_rd_data == SC_BRK) begin
                            state_nxt = ST_BRK;
                        end else if (ps2_rd_data == SC_PAUSE) begin
                            state_nxt = ST_PAUSE;
                            pause_nxt = '0;
                        end else if (is_status(ps2_rd_data)) begin
                            stat_load = 1'b1;
                        end else begin
                            evt_load = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (ps2_rd_data == SC_BRK) begin
                            state_nxt = ST_EXT_BRK;
                        end else if (is_prefix(ps2_rd_data)) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            evt_load     = 1'b1;
                            evt_data.ext = 1'b1;
                            state_nxt    = ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        state_nxt = ST_IDLE;
                        if (is_prefix(ps2_rd_data)) begin
                            err_nxt = 1'b1;
                        end else begin
                            evt_load     = 1'b1;
                            evt_data.ext = (state == ST_EXT_BRK);
                            evt_data.brk = 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        // Pause bytes are only counted, never inspected.
                        if (pause_cnt == PAUSE_LAST) begin
                            evt_load      = 1'b1;
                            evt_data.code = SC_PAUSE;
                            state_nxt     = ST_IDLE;
                        end else begin
                            pause_nxt = pause_cnt + 3'd1;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end else if (state != ST_IDLE) begin
            if (to_cnt == TO_LAST) begin
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
                to_nxt    = '0;
            end else begin
                to_nxt = to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pause_cnt  <= '0;
            to_cnt     <= '0;
            stat_valid <= 1'b0;
            stat_code  <= 8'h00;
            seq_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pause_cnt  <= pause_nxt;
            to_cnt     <= to_nxt;
            stat_valid <= stat_load;
            seq_err    <= err_nxt;
            if (stat_load) begin
                stat_code <= ps2_rd_data;
            end
        end
    end

    ps2_evt_reg u_evt_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (evt_load),
        .load_evt (evt_data),
        .ready    (key_ready),
        .valid    (key_valid),
        .evt      (evt_q),
        .ovf      (ovf)
    );

    assign key_code = evt_q.code;
    assign key_ext  = evt_q.ext;
    assign key_brk  = evt_q.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a table of single-byte vectors with
// hand-computed outputs, plus sequences for timeout, backpressure and reset.
module tb_ps2_scancode_decoder;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       kv;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       sv;
        logic [7:0] sc;
        logic       se;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_rx_done = 1'b0;
    logic [7:0] ps2_rd_data = 8'h00;
    logic       ps2_rd_data_err = 1'b0;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       stat_valid;
    logic [7:0] stat_code;
    logic       seq_err;
    logic       ovf;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_rx_done     (ps2_rx_done),
        .ps2_rd_data     (ps2_rd_data),
        .ps2_rd_data_err (ps2_rd_data_err),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .key_code        (key_code),
        .key_ext         (key_ext),
        .key_brk         (key_brk),
        .stat_valid      (stat_valid),
        .stat_code       (stat_code),
        .seq_err         (seq_err),
        .ovf             (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One byte strobe: drive at negedge, sample 1 time unit after the capturing edge.
    task automatic send(input logic [7:0] d, input logic e);
        @(negedge clk);
        ps2_rx_done     = 1'b1;
        ps2_rd_data     = d;
        ps2_rd_data_err = e;
        @(posedge clk);
        #1;
        ps2_rx_done     = 1'b0;
        ps2_rd_data_err = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] data, input logic err, input logic kv,
                                input logic [7:0] code, input logic ext, input logic brk,
                                input logic sv, input logic [7:0] sc, input logic se);
        vec_t v;
        v.data = data; v.err = err; v.kv = kv; v.code = code; v.ext = ext;
        v.brk = brk; v.sv = sv; v.sc = sc; v.se = se;
        return v;
    endfunction

    initial begin
        int first_err;
        int err_count;

        // make / break
        vecs.push_back(mk(8'h1C, 0, 1, 8'h1C, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 8'h00, 0));
        // extended make / break
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h75, 0, 1, 8'h75, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h75, 0, 1, 8'h75, 1, 1, 0, 8'h00, 0));
        // Pause: E1 14 77 E1 F0 14 F0 77, one event after the 8th byte
        vecs.push_back(mk(8'hE1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h14, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h77, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h14, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h77, 0, 1, 8'hE1, 0, 0, 0, 8'h00, 0));
        // status byte, then error byte after E0, then recovery
        vecs.push_back(mk(8'hAA, 0, 0, 8'h00, 0, 0, 1, 8'hAA, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h55, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(8'h29, 0, 1, 8'h29, 0, 0, 0, 8'h00, 0));
        // malformed prefix sequences
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(8'hE0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
        // status byte mid-sequence is data; status FA in IDLE
        vecs.push_back(mk(8'hF0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hAA, 0, 1, 8'hAA, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(8'hFA, 0, 0, 8'h00, 0, 0, 1, 8'hFA, 0));

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst key_valid", {7'd0, key_valid}, 8'h00);
        check("rst key_code", key_code, 8'h00);
        check("rst key_ext_brk", {6'd0, key_ext, key_brk}, 8'h00);
        check("rst stat_valid", {7'd0, stat_valid}, 8'h00);
        check("rst stat_code", stat_code, 8'h00);
        check("rst seq_err_ovf", {6'd0, seq_err, ovf}, 8'h00);
        rst = 1'b1;
        idle_cycle();

        // table-driven vectors, key_ready held high
        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].err);
            check($sformatf("v%0d key_valid", i), {7'd0, key_valid}, {7'd0, vecs[i].kv});
            if (vecs[i].kv) begin
                check($sformatf("v%0d key_code", i), key_code, vecs[i].code);
                check($sformatf("v%0d ext_brk", i), {6'd0, key_ext, key_brk},
                      {6'd0, vecs[i].ext, vecs[i].brk});
            end
            check($sformatf("v%0d stat_valid", i), {7'd0, stat_valid}, {7'd0, vecs[i].sv});
            if (vecs[i].sv) begin
                check($sformatf("v%0d stat_code", i), stat_code, vecs[i].sc);
            end
            check($sformatf("v%0d seq_err", i), {7'd0, seq_err}, {7'd0, vecs[i].se});
            check($sformatf("v%0d ovf", i), {7'd0, ovf}, 8'h00);
        end
        idle_cycle();

        // timeout: F0 then 40 idle cycles, seq_err expected exactly on cycle 32
        send(8'hF0, 1'b0);
        first_err = -1;
        err_count = 0;
        for (int i = 1; i <= 40; i++) begin
            idle_cycle();
            if (seq_err) begin
                err_count++;
                if (first_err < 0) first_err = i;
            end
        end
        check("timeout pulse count", 8'(err_count), 8'd1);
        check("timeout cycle", 8'(first_err), 8'd32);
        send(8'h1C, 1'b0);
        check("post-timeout key_valid", {7'd0, key_valid}, 8'h01);
        check("post-timeout key_code", key_code, 8'h1C);
        check("post-timeout ext_brk", {6'd0, key_ext, key_brk}, 8'h00);
        idle_cycle();

        // backpressure: held event, dropped event, same-cycle transfer and load
        key_ready = 1'b0;
        send(8'h1C, 1'b0);
        check("bp first valid", {7'd0, key_valid}, 8'h01);
        check("bp first ovf", {7'd0, ovf}, 8'h00);
        send(8'h32, 1'b0);
        check("bp held code", key_code, 8'h1C);
        check("bp drop ovf", {7'd0, ovf}, 8'h01);
        idle_cycle();
        check("bp ovf pulse ends", {7'd0, ovf}, 8'h00);
        check("bp still held", {7'd0, key_valid}, 8'h01);
        @(negedge clk);
        key_ready = 1'b1;
        send(8'h21, 1'b0);
        check("bp swap valid", {7'd0, key_valid}, 8'h01);
        check("bp swap code", key_code, 8'h21);
        check("bp swap ext_brk", {6'd0, key_ext, key_brk}, 8'h00);
        check("bp swap ovf", {7'd0, ovf}, 8'h00);
        idle_cycle();
        check("bp drained", {7'd0, key_valid}, 8'h00);

        // reset mid-sequence drops the held event and the pending E0
        key_ready = 1'b0;
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        check("midrst key_valid", {7'd0, key_valid}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        key_ready = 1'b1;
        send(8'h75, 1'b0);
        check("midrst key_valid after", {7'd0, key_valid}, 8'h01);
        check("midrst code", key_code, 8'h75);
        check("midrst ext_brk", {6'd0, key_ext, key_brk}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
